// File: rtl/qed_inst_pkg.sv
// Shared encodings and FSM state values for the QED original-stream instruction window.
// Imported by qed_inst_decode and qed_inst_window.
package qed_inst_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_NOP    = 7'h7F;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [1:0] {
        ST_FILL  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_DONE  = 2'b10
    } qed_state_e;

endpackage

// File: rtl/qed_inst_decode.sv
// Combinational classifier: instruction -> NOP flag, class-legal flag, register-rule flag.
// Only the low 32 bits carry the RV32IM encoding.
module qed_inst_decode
    import qed_inst_pkg::*;
#(
    parameter int INST_W        = 32,
    parameter int NUM_ORIG_REGS = 16,
    parameter int MEM_LIMIT     = 1024,
    parameter int ALLOW_MUL     = 1
) (
    input  logic [INST_W-1:0] i_instruction,
    output logic              o_is_nop,
    output logic              o_class_ok,
    output logic              o_regs_ok
);

    localparam logic [5:0] REG_LIM = 6'(NUM_ORIG_REGS);
    localparam logic [31:0] MEM_LIM = 32'(MEM_LIMIT);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [11:0] w_imm_i;
    logic [11:0] w_imm_s;
    logic        w_rd_ok;
    logic        w_rs1_ok;
    logic        w_rs2_ok;
    logic        w_imm_i_ok;
    logic        w_imm_s_ok;
    logic        w_mul_en;
    logic        w_is_nop;
    logic        w_class_ok;
    logic        w_regs_ok;

    assign w_opc   = i_instruction[6:0];
    assign w_rd    = i_instruction[11:7];
    assign w_f3    = i_instruction[14:12];
    assign w_rs1   = i_instruction[19:15];
    assign w_rs2   = i_instruction[24:20];
    assign w_f7    = i_instruction[31:25];
    assign w_imm_i = i_instruction[31:20];
    assign w_imm_s = {i_instruction[31:25], i_instruction[11:7]};

    assign w_rd_ok    = {1'b0, w_rd}  < REG_LIM;
    assign w_rs1_ok   = {1'b0, w_rs1} < REG_LIM;
    assign w_rs2_ok   = {1'b0, w_rs2} < REG_LIM;
    assign w_imm_i_ok = {20'd0, w_imm_i} < MEM_LIM;
    assign w_imm_s_ok = {20'd0, w_imm_s} < MEM_LIM;
    assign w_mul_en   = (ALLOW_MUL != 0);

    always_comb begin
        w_is_nop   = 1'b0;
        w_class_ok = 1'b0;
        w_regs_ok  = 1'b0;
        unique case (1'b1)
            (w_opc == OPC_NOP): begin
                w_is_nop   = 1'b1;
                w_class_ok = 1'b1;
                w_regs_ok  = 1'b1;
            end
            (w_opc == OPC_OP_IMM): begin
                unique case (w_f3)
                    F3_SLL:  w_class_ok = (w_f7 == F7_BASE);
                    F3_SR:   w_class_ok = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                    default: w_class_ok = 1'b1;
                endcase
                w_regs_ok = w_rs1_ok && w_rd_ok;
            end
            (w_opc == OPC_OP): begin
                // M extension: only the multiplies (funct3[2]==0), never divides
                w_class_ok = (w_f7 == F7_BASE)
                          || ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SR)))
                          || ((w_f7 == F7_MULDIV) && w_mul_en && !w_f3[2]);
                w_regs_ok  = w_rs1_ok && w_rs2_ok && w_rd_ok;
            end
            (w_opc == OPC_LOAD): begin
                w_class_ok = (w_f3 == F3_WORD) && (w_rs1 == 5'd0) && w_imm_i_ok;
                w_regs_ok  = w_rs1_ok && w_rd_ok;
            end
            (w_opc == OPC_STORE): begin
                w_class_ok = (w_f3 == F3_WORD) && (w_rs1 == 5'd0) && w_imm_s_ok;
                w_regs_ok  = w_rs1_ok && w_rs2_ok;
            end
            default: begin
                w_class_ok = 1'b0;
            end
        endcase
    end

    assign o_is_nop   = w_is_nop;
    assign o_class_ok = w_class_ok;
    assign o_regs_ok  = w_regs_ok;

endmodule

// File: rtl/qed_inst_window.sv
// SQED original-stream filter with a FILL/DRAIN/DONE window and violation monitor.
// Define QED_FORMAL_ASSUME_EN to constrain the solver to legal instructions.
module qed_inst_window
    import qed_inst_pkg::*;
#(
    parameter int INST_W        = 32,
    parameter int NUM_ORIG_REGS = 16,
    parameter int MEM_LIMIT     = 1024,
    parameter int ALLOW_MUL     = 1,
    parameter int MAX_ORIG      = 8,
    parameter int DRAIN_CYCLES  = 16,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [INST_W-1:0] instruction,
    input  logic              flush,
    output logic              inst_allowed,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  orig_count,
    output logic [CNT_W-1:0]  drain_count,
    output logic              viol,
    output logic [CNT_W-1:0]  viol_count
);

    localparam logic [CNT_W-1:0] ORIG_LAST  = CNT_W'(MAX_ORIG - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] VCNT_MAX   = '1;

    qed_state_e       r_state;
    qed_state_e       w_state_nx;
    logic [CNT_W-1:0] r_orig;
    logic [CNT_W-1:0] r_drain;
    logic             r_viol;
    logic [CNT_W-1:0] r_vcnt;

    logic w_is_nop;
    logic w_class_ok;
    logic w_regs_ok;
    logic w_allowed;
    logic w_accept;
    logic w_viol_ev;

    qed_inst_decode #(
        .INST_W        (INST_W),
        .NUM_ORIG_REGS (NUM_ORIG_REGS),
        .MEM_LIMIT     (MEM_LIMIT),
        .ALLOW_MUL     (ALLOW_MUL)
    ) u_decode (
        .i_instruction (instruction),
        .o_is_nop      (w_is_nop),
        .o_class_ok    (w_class_ok),
        .o_regs_ok     (w_regs_ok)
    );

    always_comb begin
        w_allowed = 1'b1;
        if (inst_valid) begin
            if (r_state == ST_FILL) w_allowed = w_class_ok && w_regs_ok;
            else                    w_allowed = w_is_nop;
        end
    end

    assign w_accept  = inst_valid && w_allowed && !w_is_nop && (r_state == ST_FILL);
    assign w_viol_ev = inst_valid && !w_allowed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_FILL;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_FILL: begin
                // an accept that coincides with flush still counts before closing
                if ((w_accept && (r_orig == ORIG_LAST)) || flush)
                    w_state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_drain == DRAIN_LAST) w_state_nx = ST_DONE;
            end
            default: w_state_nx = r_state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_orig  <= '0;
            r_drain <= '0;
        end else begin
            if (w_accept) r_orig <= r_orig + 1'b1;
            if (r_state == ST_DRAIN) r_drain <= r_drain + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_viol <= 1'b0;
            r_vcnt <= '0;
        end else if (w_viol_ev) begin
            r_viol <= 1'b1;
            if (r_vcnt != VCNT_MAX) r_vcnt <= r_vcnt + 1'b1;
        end
    end

`ifdef QED_FORMAL_ASSUME_EN
    a_legal_only: assume property (@(posedge clk) disable iff (rst)
        inst_valid |-> inst_allowed);
`else
    // pure monitor: illegal input is only reported through viol/viol_count
`endif

    assign inst_allowed = w_allowed;
    assign state        = r_state;
    assign orig_count   = r_orig;
    assign drain_count  = r_drain;
    assign viol         = r_viol;
    assign viol_count   = r_vcnt;

endmodule

// File: tb/tb_qed_inst_window.sv
// Scoreboard bench for qed_inst_window: expected registered outputs are queued
// when each instruction is driven and popped one edge later.
module tb_qed_inst_window;

    localparam int CNT_W = 8;

    localparam logic [31:0] I_ADDI    = 32'h00510093;
    localparam logic [31:0] I_ADD_X17 = 32'h002088B3;
    localparam logic [31:0] I_SW_OK   = 32'h00302223;
    localparam logic [31:0] I_SW_RS1  = 32'h0030A223;
    localparam logic [31:0] I_LW_1024 = 32'h40002083;
    localparam logic [31:0] I_LW_1023 = 32'h3FF02083;
    localparam logic [31:0] I_MUL     = 32'h023100B3;
    localparam logic [31:0] I_XORI    = 32'h00314093;
    localparam logic [31:0] I_SRAI    = 32'h40315093;
    localparam logic [31:0] I_SLLI_BAD= 32'h40311093;
    localparam logic [31:0] I_NOP     = 32'h0000007F;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             inst_valid = 1'b0;
    logic [31:0]      instruction = '0;
    logic             flush = 1'b0;
    logic             inst_allowed;
    logic [1:0]       state;
    logic [CNT_W-1:0] orig_count;
    logic [CNT_W-1:0] drain_count;
    logic             viol;
    logic [CNT_W-1:0] viol_count;

    logic             nm_allowed;
    logic [1:0]       nm_state;
    logic [CNT_W-1:0] nm_orig;
    logic [CNT_W-1:0] nm_drain;
    logic             nm_viol;
    logic [CNT_W-1:0] nm_vcnt;

    always #5 clk = ~clk;

    qed_inst_window #(.ALLOW_MUL(1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .inst_valid   (inst_valid),
        .instruction  (instruction),
        .flush        (flush),
        .inst_allowed (inst_allowed),
        .state        (state),
        .orig_count   (orig_count),
        .drain_count  (drain_count),
        .viol         (viol),
        .viol_count   (viol_count)
    );

    qed_inst_window #(.ALLOW_MUL(0)) u_nomul (
        .clk          (clk),
        .rst          (rst),
        .inst_valid   (inst_valid),
        .instruction  (instruction),
        .flush        (flush),
        .inst_allowed (nm_allowed),
        .state        (nm_state),
        .orig_count   (nm_orig),
        .drain_count  (nm_drain),
        .viol         (nm_viol),
        .viol_count   (nm_vcnt)
    );

    typedef struct {
        int st;
        int orig;
        int drain;
        int viol;
        int vcnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int m_st, m_orig, m_drain, m_viol, m_vcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_st = 0; m_orig = 0; m_drain = 0; m_viol = 0; m_vcnt = 0;
    endtask

    // async reset asserted mid-cycle; outputs must clear before any edge
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        inst_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk({tag, ".st"},    32'(state), 0);
        chk({tag, ".orig"},  32'(orig_count), 0);
        chk({tag, ".drain"}, 32'(drain_count), 0);
        chk({tag, ".viol"},  32'(viol), 0);
        chk({tag, ".vcnt"},  32'(viol_count), 0);
        model_clear();
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                        input logic exp_al, input string tag, input int nm_exp = -1);
        exp_t e;
        logic is_nop, acc, vev;
        inst_valid  = v;
        instruction = ins;
        flush       = fl;
        #1;
        chk({tag, ".allowed"}, 32'(inst_allowed), 32'(exp_al));
        if (nm_exp >= 0) chk({tag, ".nomul_allowed"}, 32'(nm_allowed), nm_exp);
        is_nop = (ins[6:0] == 7'h7F);
        acc    = v && exp_al && !is_nop && (m_st == 0);
        vev    = v && !exp_al;
        case (m_st)
            0: begin
                if (acc) m_orig++;
                if ((acc && m_orig == 8) || fl) m_st = 1;
            end
            1: begin
                m_drain++;
                if (m_drain == 16) m_st = 2;
            end
            default: ;
        endcase
        if (vev) begin
            m_viol = 1;
            if (m_vcnt < 255) m_vcnt++;
        end
        e.st = m_st; e.orig = m_orig; e.drain = m_drain; e.viol = m_viol; e.vcnt = m_vcnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        flush = 1'b0;
        e = sb_q.pop_front();
        chk({tag, ".st"},    32'(state), e.st);
        chk({tag, ".orig"},  32'(orig_count), e.orig);
        chk({tag, ".drain"}, 32'(drain_count), e.drain);
        chk({tag, ".viol"},  32'(viol), e.viol);
        chk({tag, ".vcnt"},  32'(viol_count), e.vcnt);
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        do_reset("rst0");

        for (int i = 0; i < 8; i++) step(1, I_ADDI, 0, 1, "addi8");
        chk("addi8.in_drain", 32'(state), 1);

        do_reset("rst1");
        step(1, I_ADD_X17, 0, 0, "add_rd17");
        step(1, I_SW_OK,   0, 1, "sw_ok");
        step(1, I_SW_RS1,  0, 0, "sw_rs1");
        step(1, I_LW_1024, 0, 0, "lw_1024");
        step(1, I_LW_1023, 0, 1, "lw_1023");
        step(1, I_SLLI_BAD,0, 0, "slli_f7");
        step(1, I_MUL,     0, 1, "mul", 0);
        step(0, I_ADD_X17, 0, 1, "idle");
        step(1, I_XORI,    1, 1, "xori_flush");
        step(1, I_NOP,     0, 1, "drain_nop");
        step(1, I_ADDI,    0, 0, "drain_addi");
        for (int i = 0; i < 14; i++) step(1, I_NOP, 0, 1, "drain_run");
        step(1, I_NOP,     1, 1, "done_flush");
        step(1, I_SRAI,    0, 0, "done_srai");

        do_reset("rst2");
        step(1, I_SRAI, 0, 1, "srai");
        step(1, I_ADDI, 0, 1, "fill_b");
        step(0, I_NOP,  1, 1, "flush_idle");
        for (int i = 0; i < 5; i++) step(1, I_NOP, 0, 1, "drain5");
        chk("drain5.cnt", 32'(drain_count), 5);
        do_reset("rst_mid_drain");

        for (int i = 0; i < 300; i++) step(1, I_ADD_X17, 0, 0, "sat");
        chk("sat.final", 32'(viol_count), 255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
